dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Shares the single D-mem request/response port between two requesters: port 0 (load/store pipeline) and port 1 (auxiliary master, e.g. page-table walker or debug).
- Arbitrates requests, holds a grant stable until the downstream handshake, and routes in-order responses back to the owner via an outstanding-owner FIFO.
- Sits between the requesters and the D-cache/bus adapter; adds zero request latency and zero response latency.

Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered requests (power of two, 2..16).
- CNT_W, $clog2(MAX_OUTSTANDING)+1, occupancy counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- p0_req_addr / p1_req_addr  in  64  request address
- p0_req_wdata / p1_req_wdata  in  64  store data
- p0_req_wmask / p1_req_wmask  in  8  byte mask
- p0_req_wen / p1_req_wen  in  1  1 = store
- p0_req_valid / p1_req_valid  in  1  request valid
- p0_req_ready / p1_req_ready  out  1  request accepted
- p0_resp_rdata / p1_resp_rdata  out  64  response data
- p0_resp_valid / p1_resp_valid  out  1  response strobe (no back-pressure)
- dm_req_addr  out  64  downstream address
- dm_req_wdata  out  64  downstream data
- dm_req_wmask  out  8  downstream mask
- dm_req_wen  out  1  downstream write enable
- dm_req_valid  out  1  downstream valid
- dm_req_ready  in  1  downstream ready
- dm_resp_rdata  in  64  downstream response data
- dm_resp_valid  in  1  downstream response strobe
- dmarb_busy  out  1  outstanding count != 0 or dm_req_valid
- dmarb_err  out  1  sticky protocol error

Behaviour:
- Reset (rst low, async): lock FSM = IDLE, owner FIFO empty, count 0, rr pointer 0, dmarb_err 0. All valid/ready outputs are combinational and therefore 0 during reset; data outputs are don't-care.
- Each request, loads and stores alike, produces exactly one dm_resp_valid. Responses return in request order.
- Grant is possible only when count < MAX_OUTSTANDING. When count == MAX_OUTSTANDING: dm_req_valid = 0 and both readys = 0. A same-cycle pop does not free a slot for that cycle.
- Lock FSM, IDLE:
  - Select a requester per the priority rule.
  - Drive dm_req_* combinationally from the selected port; dm_req_valid = selected valid.
  - Selected pX_req_ready = dm_req_ready. The other port's ready = 0.
  - dm_req_valid && !dm_req_ready → go to LOCKED, remembering the owner.
- Lock FSM, LOCKED:
  - Mux is forced to the remembered owner, whatever the other port does.
  - Handshake → IDLE.
  - If the owner drops valid before the handshake (protocol violation): dmarb_err set, return to IDLE.
- Handshake (dm_req_valid && dm_req_ready): push the owner bit into the FIFO; count +1.
- dm_resp_valid:
  - Pop the FIFO head; count −1.
  - pX_resp_valid = 1 for the head owner only, same cycle. dm_resp_rdata is fanned to both rdata ports.
- Push and pop in the same cycle: count unchanged; the FIFO pointers both advance and wrap modulo MAX_OUTSTANDING.
- dm_resp_valid with count == 0: no pop, both resp_valid = 0, dmarb_err set. dmarb_err clears only on reset.
- Default priority: fixed, port 0 over port 1.

Optional Feature:
- Macro DMARB_ROUND_ROBIN_EN.
- Defined: 1-bit rr pointer names the preferred port. After each handshake in IDLE or LOCKED, the pointer moves to the non-granted port. Grant goes to the preferred port if it is valid, otherwise to the other port.
- Undefined: fixed priority, port 0 always wins, no pointer flop.

Decomposition:
- Shared defines file: DMARB_OWNER_LSP = 1'b0, DMARB_OWNER_AUX = 1'b1, lock FSM state encodings (IDLE = 1'b0, LOCKED = 1'b1).
- One natural sub-module, dm_arbiter_owner_fifo: 1-bit-wide, MAX_OUTSTANDING-deep synchronous FIFO with push/pop, full/empty and count; asynchronous active-low reset.

Test Plan:
- Contention: p0 and p1 both valid, dm_req_ready = 1, addresses 0x1000 and 0x2000 → cycle 0 grants p0 (0x1000). Cycle 1 grants p1. Responses 0xAA then 0xBB arrive on p0 then p1.
- Lock: p1 alone valid at 0x3008, dm_req_ready = 0 for 3 cycles while p0 raises valid in cycle 1 → dm_req_addr stays 0x3008 until the handshake in cycle 3; p0_req_ready = 0 throughout.
- Full: MAX_OUTSTANDING = 4, four p0 handshakes with no response → fifth request sees dm_req_valid = 0. A single dm_resp_valid → next cycle grants; count returns to 4.
- Simultaneous push/pop at count = 2 → count stays 2; owner ordering preserved across pointer wrap after 10 transactions.
- Spurious dm_resp_valid at count = 0 → dmarb_err = 1 and stays 1. Both resp_valid = 0.
- With DMARB_ROUND_ROBIN_EN, both ports continuously valid for 6 handshakes → grants alternate p0, p1, p0, p1, p0, p1. Without the macro → six grants to p0.

Source files
------------

// File: rtl/dm_arbiter_pkg.sv
// Shared types and constants for the D-mem port arbiter.
package dm_arbiter_pkg;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int MASK_W = 8;

  localparam logic DMARB_OWNER_LSP = 1'b0;
  localparam logic DMARB_OWNER_AUX = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } lock_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
    logic              wen;
  } dmarb_req_t;
endpackage

// File: rtl/dm_arbiter_if.sv
// Request/response bundle for one D-mem port; master issues requests, slave answers.
interface dm_arbiter_if;
  import dm_arbiter_pkg::*;

  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [MASK_W-1:0] req_wmask;
  logic              req_wen;
  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_valid;

  modport master (
    output req_addr, req_wdata, req_wmask, req_wen, req_valid,
    input  req_ready, resp_rdata, resp_valid
  );

  modport slave (
    input  req_addr, req_wdata, req_wmask, req_wen, req_valid,
    output req_ready, resp_rdata, resp_valid
  );
endinterface

// File: rtl/dm_arbiter_owner_fifo.sv
// 1-bit owner FIFO tracking which requester each outstanding D-mem access belongs to.
module dm_arbiter_owner_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             din,
  input  logic             pop,
  output logic             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/dm_arbiter.sv
// Two-requester D-mem arbiter with grant lock and in-order response routing.
// Optional round-robin priority: define DMARB_ROUND_ROBIN_EN (default is fixed, port 0 first).
module dm_arbiter
  import dm_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic         clk,
  input  logic         rst,
  dm_arbiter_if.slave  p0,
  dm_arbiter_if.slave  p1,
  dm_arbiter_if.master dm,
  output logic         dmarb_busy,
  output logic         dmarb_err
);
  dmarb_req_t [1:0] req;
  logic       [1:0] req_valid;

  lock_state_e state_q, state_d;
  logic        owner_q, owner_d;
  logic        pref_sel, sel;
  logic        can_grant, hs, pop, proto_err;
  logic        head, full, empty;
  logic [CNT_W-1:0] count;

  assign req[0] = '{addr: p0.req_addr, wdata: p0.req_wdata, wmask: p0.req_wmask, wen: p0.req_wen};
  assign req[1] = '{addr: p1.req_addr, wdata: p1.req_wdata, wmask: p1.req_wmask, wen: p1.req_wen};
  assign req_valid = {p1.req_valid, p0.req_valid};

`ifdef DMARB_ROUND_ROBIN_EN
  logic rr_q;

  assign pref_sel = req_valid[rr_q] ? rr_q : ~rr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)    rr_q <= DMARB_OWNER_LSP;
    else if (hs) rr_q <= ~sel;
  end
`else
  assign pref_sel = req_valid[0] ? DMARB_OWNER_LSP : DMARB_OWNER_AUX;
`endif

  // Registered count only: a pop in this cycle frees its slot next cycle
  assign can_grant = rst & ~full;
  assign sel       = (state_q == LOCKED) ? owner_q : pref_sel;

  assign dm.req_addr  = req[sel].addr;
  assign dm.req_wdata = req[sel].wdata;
  assign dm.req_wmask = req[sel].wmask;
  assign dm.req_wen   = req[sel].wen;
  assign dm.req_valid = can_grant & req_valid[sel];
  assign hs           = dm.req_valid & dm.req_ready;

  assign p0.req_ready = can_grant & dm.req_ready & (sel == DMARB_OWNER_LSP);
  assign p1.req_ready = can_grant & dm.req_ready & (sel == DMARB_OWNER_AUX);

  assign pop           = dm.resp_valid & ~empty;
  assign p0.resp_valid = pop & (head == DMARB_OWNER_LSP);
  assign p1.resp_valid = pop & (head == DMARB_OWNER_AUX);
  assign p0.resp_rdata = dm.resp_rdata;
  assign p1.resp_rdata = dm.resp_rdata;

  assign dmarb_busy = (count != '0) | dm.req_valid;

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    proto_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (dm.req_valid && !dm.req_ready) begin
          state_d = LOCKED;
          owner_d = sel;
        end
      end
      LOCKED: begin
        if (hs) begin
          state_d = IDLE;
        end else if (!req_valid[owner_q]) begin
          state_d   = IDLE;
          proto_err = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= DMARB_OWNER_LSP;
      dmarb_err <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      dmarb_err <= dmarb_err | proto_err | (dm.resp_valid & empty);
    end
  end

  dm_arbiter_owner_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .CNT_W (CNT_W)
  ) u_owner_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (hs),
    .din   (sel),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );
endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter; owner scoreboard filled at grant, drained at response.
module tb_dm_arbiter;
  import dm_arbiter_pkg::*;

  localparam int MAXO = 4;
`ifdef DMARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic busy, err;
  int   checks = 0;
  int   errors = 0;
  logic exp_q[$];

  always #5 clk = ~clk;

  dm_arbiter_if p0_if ();
  dm_arbiter_if p1_if ();
  dm_arbiter_if dm_if ();

  dm_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk        (clk),
    .rst        (rst),
    .p0         (p0_if),
    .p1         (p1_if),
    .dm         (dm_if),
    .dmarb_busy (busy),
    .dmarb_err  (err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int p, input logic v, input logic [63:0] a);
    if (p == 0) begin
      p0_if.req_valid = v; p0_if.req_addr = a;
      p0_if.req_wdata = a ^ 64'hFF; p0_if.req_wmask = 8'h0F; p0_if.req_wen = a[3];
    end else begin
      p1_if.req_valid = v; p1_if.req_addr = a;
      p1_if.req_wdata = a ^ 64'hFF; p1_if.req_wmask = 8'hF0; p1_if.req_wen = a[3];
    end
  endtask

  // Expect port p granted this cycle with address a; record owner for its response
  task automatic grant(input int p, input logic [63:0] a);
    logic own;
    own = (p != 0);
    check("dm_valid", dm_if.req_valid, 1'b1);
    check("dm_addr", dm_if.req_addr, a);
    check("dm_wdata", dm_if.req_wdata, a ^ 64'hFF);
    check("p0_ready", p0_if.req_ready, !own);
    check("p1_ready", p1_if.req_ready, own);
    exp_q.push_back(own);
  endtask

  task automatic resp(input logic [63:0] d);
    logic own;
    if (exp_q.size() == 0) begin
      check("sb_underflow", 64'(exp_q.size()), 64'd1);
    end else begin
      own = exp_q.pop_front();
      dm_if.resp_valid = 1'b1;
      dm_if.resp_rdata = d;
      #1;
      check("p0_resp_valid", p0_if.resp_valid, !own);
      check("p1_resp_valid", p1_if.resp_valid, own);
      check("resp_rdata", own ? p1_if.resp_rdata : p0_if.resp_rdata, d);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    set_req(0, 1'b0, 64'h0);
    set_req(1, 1'b0, 64'h0);
    dm_if.req_ready  = 1'b0;
    dm_if.resp_valid = 1'b0;
    dm_if.resp_rdata = '0;

    // reset: outputs held low even with a valid request pending
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 1'b1, 64'h55);
    dm_if.req_ready = 1'b1;
    #1;
    check("rst_dm_valid", dm_if.req_valid, 1'b0);
    check("rst_p0_ready", p0_if.req_ready, 1'b0);
    check("rst_p1_ready", p1_if.req_ready, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_busy", busy, 1'b0);
    set_req(0, 1'b0, 64'h0);
    dm_if.req_ready = 1'b0;
    rst = 1'b1;
    cyc();

    // contention: p0 first, then p1; responses routed in order
    set_req(0, 1'b1, 64'h1000);
    set_req(1, 1'b1, 64'h2000);
    dm_if.req_ready = 1'b1;
    #1; grant(0, 64'h1000);
    cyc();
    set_req(0, 1'b0, 64'h0);
    #1; grant(1, 64'h2000);
    cyc();
    set_req(1, 1'b0, 64'h0);
    dm_if.req_ready = 1'b0;
    #1;
    check("cont_idle_valid", dm_if.req_valid, 1'b0);
    check("cont_busy", busy, 1'b1);
    resp(64'hAA);
    cyc();
    resp(64'hBB);
    cyc();
    dm_if.resp_valid = 1'b0;
    #1; check("cont_not_busy", busy, 1'b0);

    // lock: p1 holds the mux while p0 arrives
    set_req(1, 1'b1, 64'h3008);
    #1;
    check("lock_addr0", dm_if.req_addr, 64'h3008);
    check("lock_valid0", dm_if.req_valid, 1'b1);
    cyc();
    set_req(0, 1'b1, 64'h4000);
    #1;
    check("lock_addr1", dm_if.req_addr, 64'h3008);
    check("lock_p0_ready1", p0_if.req_ready, 1'b0);
    cyc();
    #1;
    check("lock_addr2", dm_if.req_addr, 64'h3008);
    check("lock_p0_ready2", p0_if.req_ready, 1'b0);
    cyc();
    dm_if.req_ready = 1'b1;
    #1; grant(1, 64'h3008);
    cyc();
    set_req(0, 1'b0, 64'h0);
    set_req(1, 1'b0, 64'h0);
    dm_if.req_ready = 1'b0;
    resp(64'hCC);
    cyc();
    dm_if.resp_valid = 1'b0;

    // full: four outstanding blocks the fifth until a response lands
    dm_if.req_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1'b1, 64'h5000 + 64'(i * 8));
      #1; grant(0, 64'h5000 + 64'(i * 8));
      cyc();
    end
    set_req(0, 1'b1, 64'h5100);
    #1;
    check("full_dm_valid", dm_if.req_valid, 1'b0);
    check("full_p0_ready", p0_if.req_ready, 1'b0);
    check("full_busy", busy, 1'b1);
    resp(64'h10);
    check("full_same_cycle_pop", dm_if.req_valid, 1'b0);
    cyc();
    dm_if.resp_valid = 1'b0;
    #1; grant(0, 64'h5100);
    cyc();
    #1; check("full_again", dm_if.req_valid, 1'b0);
    set_req(0, 1'b0, 64'h0);
    dm_if.req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      resp(64'h20 + 64'(i));
      cyc();
    end
    dm_if.resp_valid = 1'b0;
    #1; check("drain_busy", busy, 1'b0);

    // push+pop at count 2 across pointer wrap, alternating owners
    dm_if.req_ready = 1'b1;
    set_req(0, 1'b1, 64'h6000);
    #1; grant(0, 64'h6000);
    cyc();
    set_req(0, 1'b0, 64'h0);
    set_req(1, 1'b1, 64'h6008);
    #1; grant(1, 64'h6008);
    cyc();
    for (int k = 0; k < 8; k++) begin
      set_req(k % 2, 1'b1, 64'h7000 + 64'(k * 8));
      set_req(1 - (k % 2), 1'b0, 64'h0);
      #1; grant(k % 2, 64'h7000 + 64'(k * 8));
      resp(64'h300 + 64'(k));
      cyc();
    end
    dm_if.resp_valid = 1'b0;
    set_req(1, 1'b0, 64'h0);
    set_req(0, 1'b1, 64'h8000);
    #1; grant(0, 64'h8000);
    cyc();
    #1; grant(0, 64'h8000);
    cyc();
    #1; check("wrap_full", dm_if.req_valid, 1'b0);
    set_req(0, 1'b0, 64'h0);
    dm_if.req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      resp(64'h380 + 64'(i));
      cyc();
    end
    dm_if.resp_valid = 1'b0;

    // owner drops valid while locked
    set_req(1, 1'b1, 64'h9000);
    #1; check("pre_drop_err", err, 1'b0);
    cyc();
    set_req(1, 1'b0, 64'h0);
    cyc();
    #1;
    check("lock_drop_err", err, 1'b1);
    check("lock_drop_idle", dm_if.req_valid, 1'b0);
    rst = 1'b0;
    #1; check("rst_clears_err", err, 1'b0);
    cyc();
    rst = 1'b1;

    // spurious response with nothing outstanding
    cyc();
    #1; check("pre_spur_err", err, 1'b0);
    dm_if.resp_valid = 1'b1;
    dm_if.resp_rdata = 64'hDEAD;
    #1;
    check("spur_p0_resp", p0_if.resp_valid, 1'b0);
    check("spur_p1_resp", p1_if.resp_valid, 1'b0);
    cyc();
    dm_if.resp_valid = 1'b0;
    #1; check("spur_err", err, 1'b1);
    repeat (3) cyc();
    check("spur_err_sticky", err, 1'b1);

    // six back-to-back grants with both ports valid
    set_req(0, 1'b1, 64'hA000);
    set_req(1, 1'b1, 64'hB000);
    dm_if.req_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      int p;
      p = RR ? (k % 2) : 0;
      #1; grant(p, (p != 0) ? 64'hB000 : 64'hA000);
      if (k >= 2) resp(64'h400 + 64'(k));
      cyc();
    end
    set_req(0, 1'b0, 64'h0);
    set_req(1, 1'b0, 64'h0);
    dm_if.req_ready = 1'b0;
    resp(64'h500);
    cyc();
    resp(64'h501);
    cyc();
    dm_if.resp_valid = 1'b0;
    #1;
    check("end_busy", busy, 1'b0);
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
